// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage -- memory-stage load/store unit.
//
// Takes one load or store from the M stage and runs it as a
// request / grant / response transaction on the data-memory bus. While it runs,
// the unit stalls the upstream pipeline. Load data is returned lane-extracted
// and sign- or zero-extended.
//
// Ports
//   clk, reset_n         clock; asynchronous active-low reset
//   req_valid/req_write  M-stage instruction is a memory op; 1 = store
//   req_addr/req_wdata   effective address, store data
//   req_trunc            size/sign code (encoding below)
//   flush                kill the in-flight M-stage instruction
//   stall                hold upstream stages
//   resp_valid           1-cycle pulse: access done, load_data valid
//   load_data            extended load result (0 for stores)
//   misaligned           1-cycle pulse, one cycle after a rejected request
//   mem_req .. mem_wstrb bus request channel
//   mem_gnt              request accepted this cycle
//   mem_rvalid/mem_rdata response (stores also get an rvalid ack)
//
// req_trunc encoding:
//   0 BYTE, 1 HALF_WORD, 2 WORD, 3 BYTE_UNSIGNED,
//   4 HALF_WORD_UNSIGNED, 5 WORD_UNSIGNED, 6 NO_TRUNC.
//   Code 7 behaves as NO_TRUNC.
module lsu_mem_stage #(
`ifdef BIT_COUNT_64
  parameter int XLEN = 64,
`else
  parameter int XLEN = 32,
`endif
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [2:0]        req_trunc,
  input  logic              flush,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   load_data,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int OFF_W = $clog2(STRB_W);

  localparam logic [2:0] TR_BYTE   = 3'd0;
  localparam logic [2:0] TR_HALF   = 3'd1;
  localparam logic [2:0] TR_WORD   = 3'd2;
  localparam logic [2:0] TR_BYTE_U = 3'd3;
  localparam logic [2:0] TR_HALF_U = 3'd4;
  localparam logic [2:0] TR_WORD_U = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Natural alignment check; full-width accesses need offset 0.
  function automatic logic is_aligned(input logic [2:0] trunc, input logic [OFF_W-1:0] off);
    logic ok;
    case (trunc)
      TR_BYTE, TR_BYTE_U: ok = 1'b1;
      TR_HALF, TR_HALF_U: ok = (off[0] == 1'b0);
      TR_WORD, TR_WORD_U: ok = (off[1:0] == 2'b00);
      default:            ok = (off == {OFF_W{1'b0}});
    endcase
    return ok;
  endfunction

  // Replicate the store item across every lane so any offset finds it.
  function automatic logic [XLEN-1:0] store_data(input logic [2:0] trunc, input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] d;
    case (trunc)
      TR_BYTE, TR_BYTE_U: d = {STRB_W{wdata[7:0]}};
      TR_HALF, TR_HALF_U: d = {(STRB_W/2){wdata[15:0]}};
      TR_WORD, TR_WORD_U: d = {(STRB_W/4){wdata[31:0]}};
      default:            d = wdata;
    endcase
    return d;
  endfunction

  // Byte enables for the addressed lanes.
  function automatic logic [STRB_W-1:0] store_strb(input logic [2:0] trunc, input logic [OFF_W-1:0] off);
    logic [STRB_W-1:0] s;
    case (trunc)
      TR_BYTE, TR_BYTE_U: s = STRB_W'(1'b1) << off;
      TR_HALF, TR_HALF_U: s = STRB_W'(2'b11) << off;
      TR_WORD, TR_WORD_U: s = STRB_W'(4'hF) << off;
      default:            s = {STRB_W{1'b1}};
    endcase
    return s;
  endfunction

  // Pull the addressed lane down to bit 0, then extend it to XLEN.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic [2:0] trunc);
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] res;
    lane = rdata >> {off, 3'b000};
    case (trunc)
      TR_BYTE:   res = XLEN'($signed(lane[7:0]));
      TR_HALF:   res = XLEN'($signed(lane[15:0]));
      TR_WORD:   res = XLEN'($signed(lane[31:0]));
      TR_BYTE_U: res = XLEN'(lane[7:0]);
      TR_HALF_U: res = XLEN'(lane[15:0]);
      TR_WORD_U: res = XLEN'(lane[31:0]);
      default:   res = rdata;
    endcase
    return res;
  endfunction

  state_t            state_r, state_n;
  logic [XLEN-1:0]   addr_r, addr_n;
  logic [XLEN-1:0]   wdata_r, wdata_n;
  logic [STRB_W-1:0] wstrb_r, wstrb_n;
  logic              we_r, we_n;
  logic [2:0]        trunc_r, trunc_n;
  logic [OFF_W-1:0]  off_r, off_n;
  logic              kill_r, kill_n;
  logic [XLEN-1:0]   load_data_r, load_data_n;
  logic              mis_r, mis_n;
  logic              aligned_s;
  logic              accept_s;
  logic              stall_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      addr_r      <= {XLEN{1'b0}};
      wdata_r     <= {XLEN{1'b0}};
      wstrb_r     <= {STRB_W{1'b0}};
      we_r        <= 1'b0;
      trunc_r     <= 3'd0;
      off_r       <= {OFF_W{1'b0}};
      kill_r      <= 1'b0;
      load_data_r <= {XLEN{1'b0}};
      mis_r       <= 1'b0;
    end else begin
      state_r     <= state_n;
      addr_r      <= addr_n;
      wdata_r     <= wdata_n;
      wstrb_r     <= wstrb_n;
      we_r        <= we_n;
      trunc_r     <= trunc_n;
      off_r       <= off_n;
      kill_r      <= kill_n;
      load_data_r <= load_data_n;
      mis_r       <= mis_n;
    end
  end

  // Next-state logic, request capture and load-data capture.
  always_comb begin
    state_n     = state_r;
    addr_n      = addr_r;
    wdata_n     = wdata_r;
    wstrb_n     = wstrb_r;
    we_n        = we_r;
    trunc_n     = trunc_r;
    off_n       = off_r;
    kill_n      = kill_r;
    load_data_n = load_data_r;
    mis_n       = 1'b0;
    accept_s    = 1'b0;
    aligned_s   = is_aligned(req_trunc, req_addr[OFF_W-1:0]);

    case (state_r)
      S_IDLE: begin
        if (req_valid && !flush) begin
          if (aligned_s) begin
            accept_s = 1'b1;
            state_n  = S_REQ;
            addr_n   = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            wdata_n  = store_data(req_trunc, req_wdata);
            wstrb_n  = store_strb(req_trunc, req_addr[OFF_W-1:0]);
            we_n     = req_write;
            trunc_n  = req_trunc;
            off_n    = req_addr[OFF_W-1:0];
            kill_n   = 1'b0;
          end else begin
            mis_n = 1'b1;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_REQ: begin
        if (flush) begin
          // A grant in the flush cycle is still a bus transaction, so the
          // response has to be drained with the kill flag set.
          if (mem_gnt) begin
            kill_n  = 1'b1;
            state_n = S_WAIT;
          end else begin
            state_n = S_IDLE;
          end
        end else if (mem_gnt) begin
          state_n = S_WAIT;
        end else begin
          state_n = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (kill_r || flush) begin
            kill_n  = 1'b0;
            state_n = S_IDLE;
          end else begin
            state_n     = S_DONE;
            load_data_n = we_r ? {XLEN{1'b0}} : load_extend(mem_rdata, off_r, trunc_r);
          end
        end else if (flush) begin
          kill_n = 1'b1;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        kill_n  = 1'b0;
      end
    endcase

    stall_s = accept_s || (state_r == S_REQ) || (state_r == S_WAIT);
  end

  assign stall      = stall_s;
  assign resp_valid = (state_r == S_DONE);
  assign load_data  = load_data_r;
  assign misaligned = mis_r;
  assign mem_req    = (state_r == S_REQ);
  assign mem_we     = (state_r == S_REQ) && we_r;
  assign mem_addr   = addr_r;
  assign mem_wdata  = wdata_r;
  assign mem_wstrb  = wstrb_r;

endmodule
